// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit.
//   fwd_sel_t  : E-stage forwarding mux select (register file / W result / M ALU result)
//   reg_addr_t : register-file address
//   e_stage_t, m_stage_t, w_stage_t : shadow copies of the pipeline control that
//                                     the hazard unit tracks for E, M and W
package hazard_pkg;

   localparam int unsigned HZ_REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef logic [HZ_REG_AW-1:0] reg_addr_t;

   typedef struct packed {
      reg_addr_t rs1;
      reg_addr_t rs2;
      logic      use_rs1;
      logic      use_rs2;
      reg_addr_t rd;
      logic      regwrite;
      logic      load;
   } e_stage_t;

   typedef struct packed {
      reg_addr_t rd;
      logic      regwrite;
      logic      load;
   } m_stage_t;

   typedef struct packed {
      reg_addr_t rd;
      logic      regwrite;
   } w_stage_t;

endpackage

// File: rtl/hazard_unit_fwd_sel_gen.sv
// Forward-select generator for one E-stage source operand.
//   rs_e, use_e            : source register of the instruction in E and whether it is read
//   rd_m, regwrite_m       : producer currently in M
//   rd_w, regwrite_w       : producer currently in W
//   fwd_sel                : FWD_M if M produces rs_e, else FWD_W if W does, else FWD_RF
// x0 is hard-wired zero and is never forwarded.
module fwd_sel_gen
   import hazard_pkg::*;
(
   input  reg_addr_t rs_e,
   input  logic      use_e,
   input  reg_addr_t rd_m,
   input  logic      regwrite_m,
   input  reg_addr_t rd_w,
   input  logic      regwrite_w,
   output fwd_sel_t  fwd_sel
);

   always_comb begin
      fwd_sel = FWD_RF;
      if (use_e && (rs_e != '0)) begin
         // M is the younger producer, so it takes priority over W
         if (regwrite_m && (rd_m == rs_e)) begin
            fwd_sel = FWD_M;
         end else if (regwrite_w && (rd_w == rs_e)) begin
            fwd_sel = FWD_W;
         end
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for a 5-stage (F/D/E/M/W) pipeline.
// Tracks a shadow copy of the E/M/W register addresses and write controls and derives:
//   forward_srcA_e/forward_srcB_e : E-stage operand forwarding selects (00 RF, 01 W, 10 M)
//   stall_f/stall_d              : hold PC and F/D register on a load-use hazard
//   flush_d/flush_e              : clear F/D and D/E registers (taken branch / bubble)
//   stall_cnt/flush_cnt          : free-running wrap-around event counters
// Inputs: clk, rst_n (async, active-low), D-stage instruction fields, pcsrc_e.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = HZ_REG_AW,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic              use_rs1_d,
   input  logic              use_rs2_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              regwrite_d,
   input  logic              load_d,
   input  logic              pcsrc_e,
   output logic [1:0]        forward_srcA_e,
   output logic [1:0]        forward_srcB_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   e_stage_t         e_q, e_d;
   m_stage_t         m_q, m_d;
   w_stage_t         w_q, w_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lw_stall;
   fwd_sel_t         fwd_a, fwd_b;

   // Load-use: the load in E cannot supply its result until it leaves M,
   // so a dependent instruction in D waits one cycle behind a bubble.
   always_comb begin
      lw_stall = e_q.load && (e_q.rd != '0) &&
                 ((use_rs1_d && (rs1_d == e_q.rd)) ||
                  (use_rs2_d && (rs2_d == e_q.rd)));
   end

   // A taken branch squashes D anyway, so it overrides the stall.
   always_comb begin
      stall_f = lw_stall && !pcsrc_e;
      stall_d = lw_stall && !pcsrc_e;
      flush_d = pcsrc_e;
      flush_e = lw_stall || pcsrc_e;
   end

   always_comb begin
      e_d = '0;
      if (!flush_e) begin
         e_d.rs1      = rs1_d;
         e_d.rs2      = rs2_d;
         e_d.use_rs1  = use_rs1_d;
         e_d.use_rs2  = use_rs2_d;
         e_d.rd       = rd_d;
         e_d.regwrite = regwrite_d;
         e_d.load     = load_d;
      end
      m_d.rd       = e_q.rd;
      m_d.regwrite = e_q.regwrite;
      m_d.load     = e_q.load;
      w_d.rd       = m_q.rd;
      w_d.regwrite = m_q.regwrite;
      stall_cnt_d  = stall_d ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d  = pcsrc_e ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q         <= '0;
         m_q         <= '0;
         w_q         <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         e_q         <= e_d;
         m_q         <= m_d;
         w_q         <= w_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   fwd_sel_gen u_fwd_a (
      .rs_e       (e_q.rs1),
      .use_e      (e_q.use_rs1),
      .rd_m       (m_q.rd),
      .regwrite_m (m_q.regwrite),
      .rd_w       (w_q.rd),
      .regwrite_w (w_q.regwrite),
      .fwd_sel    (fwd_a)
   );

   fwd_sel_gen u_fwd_b (
      .rs_e       (e_q.rs2),
      .use_e      (e_q.use_rs2),
      .rd_m       (m_q.rd),
      .regwrite_m (m_q.regwrite),
      .rd_w       (w_q.rd),
      .regwrite_w (w_q.regwrite),
      .fwd_sel    (fwd_b)
   );

   assign forward_srcA_e = fwd_a;
   assign forward_srcB_e = fwd_b;
   assign stall_cnt      = stall_cnt_q;
   assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: forwarding priority, x0 handling,
// load-use stall, branch-over-stall priority and asynchronous reset.
module tb_hazard_unit;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1_d, rs2_d, rd_d;
   logic        use_rs1_d, use_rs2_d, regwrite_d, load_d, pcsrc_e;
   logic [1:0]  forward_srcA_e, forward_srcB_e;
   logic        stall_f, stall_d, flush_d, flush_e;
   logic [31:0] stall_cnt, flush_cnt;

   int unsigned n_total;
   int unsigned n_pass;

   hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rs1_d          (rs1_d),
      .rs2_d          (rs2_d),
      .use_rs1_d      (use_rs1_d),
      .use_rs2_d      (use_rs2_d),
      .rd_d           (rd_d),
      .regwrite_d     (regwrite_d),
      .load_d         (load_d),
      .pcsrc_e        (pcsrc_e),
      .forward_srcA_e (forward_srcA_e),
      .forward_srcB_e (forward_srcB_e),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .flush_d        (flush_d),
      .flush_e        (flush_e),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
      rs1_d      = rs1;
      rs2_d      = rs2;
      use_rs1_d  = u1;
      use_rs2_d  = u2;
      rd_d       = rd;
      regwrite_d = rw;
      load_d     = ld;
      #1;
   endtask

   task automatic nop();
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // advance one clock; inputs are changed and outputs sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      pcsrc_e = 1'b0;
      nop();

      // reset state
      check("rst_fwdA", {30'd0, forward_srcA_e}, 32'd0);
      check("rst_fwdB", {30'd0, forward_srcB_e}, 32'd0);
      check("rst_stall", {30'd0, stall_f, stall_d}, 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_flush_cnt", flush_cnt, 32'd0);
      pcsrc_e = 1'b1;
      #1;
      check("rst_flush_pass", {30'd0, flush_d, flush_e}, 32'd3);
      pcsrc_e = 1'b0;
      #1;
      check("rst_flush_clr", {30'd0, flush_d, flush_e}, 32'd0);
      step();
      step();
      #2 rst_n = 1'b1;
      step();

      // add x5 ; sub rs1=x5 ; and rs1=x5
      set_d(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
      step();
      set_d(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      step();
      set_d(5'd5, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
      check("fwdA_M", {30'd0, forward_srcA_e}, 32'd2);
      check("fwdB_none", {30'd0, forward_srcB_e}, 32'd0);
      check("no_stall_1", {30'd0, stall_f, stall_d}, 32'd0);
      step();
      nop();
      check("fwdA_W", {30'd0, forward_srcA_e}, 32'd1);
      check("no_stall_2", {30'd0, stall_f, stall_d, flush_e}, 32'd0);
      step(); step(); step();

      // two producers of x7 (W older, M younger); consumer reads rs2=x7
      set_d(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      step();
      set_d(5'd3, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      step();
      set_d(5'd0, 5'd7, 1'b0, 1'b1, 5'd11, 1'b1, 1'b0);
      step();
      nop();
      check("fwdB_M_wins", {30'd0, forward_srcB_e}, 32'd2);
      check("fwdA_unused", {30'd0, forward_srcA_e}, 32'd0);
      step(); step(); step();

      // lw x3 ; consumer rs2=x3
      set_d(5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
      step();
      set_d(5'd1, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      check("lu_stall", {28'd0, stall_f, stall_d, flush_e, flush_d}, 32'hE);
      check("lu_cnt_before", stall_cnt, 32'd0);
      step();
      check("lu_stall_1cyc", {28'd0, stall_f, stall_d, flush_e, flush_d}, 32'h0);
      check("lu_cnt_after", stall_cnt, 32'd1);
      step();
      nop();
      check("lu_fwdB_W", {30'd0, forward_srcB_e}, 32'd1);
      check("lu_fwdA_none", {30'd0, forward_srcA_e}, 32'd0);
      step(); step(); step();

      // writes to x0 in M and W; consumer reads x0
      set_d(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
      step();
      set_d(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
      step();
      set_d(5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
      step();
      nop();
      check("x0_no_fwd", {28'd0, forward_srcA_e, forward_srcB_e}, 32'd0);
      step(); step(); step();
      // lw x0 ; consumer of x0
      set_d(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
      step();
      set_d(5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
      check("x0_no_stall", {29'd0, stall_f, stall_d, flush_e}, 32'd0);
      step(); nop(); step(); step();

      // taken branch while a load-use hazard is present
      set_d(5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
      step();
      set_d(5'd4, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);
      pcsrc_e = 1'b1;
      #1;
      check("br_over_stall", {28'd0, stall_f, stall_d, flush_d, flush_e}, 32'h3);
      check("br_flush_cnt0", flush_cnt, 32'd0);
      step();
      pcsrc_e = 1'b0;
      nop();
      check("br_flush_cnt1", flush_cnt, 32'd1);
      check("br_stall_cnt", stall_cnt, 32'd1);
      step(); step(); step();

      // asynchronous reset while a forward is active
      set_d(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
      step();
      set_d(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
      step();
      check("pre_rst_fwdA", {30'd0, forward_srcA_e}, 32'd2);
      rst_n = 1'b0;
      #1;
      check("arst_fwdA", {30'd0, forward_srcA_e}, 32'd0);
      check("arst_stall_cnt", stall_cnt, 32'd0);
      check("arst_flush_cnt", flush_cnt, 32'd0);
      nop();
      #2 rst_n = 1'b1;
      set_d(5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      check("post_rst_no_stall", {29'd0, stall_f, stall_d, flush_e}, 32'd0);
      step();
      nop();
      check("post_rst_fwd", {28'd0, forward_srcA_e, forward_srcB_e}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard detection and forwarding control for the 5-stage RISC-V pipeline (F, D, E, M, W).
- Keeps its own shadow pipeline of register addresses and write controls for E, M and W.
- From that state it drives the 2-bit forward selects for the E-stage srcA/srcB forwarding muxes, plus the stall/flush controls for the F/D and D/E pipeline registers.
- Also counts stall and flush events for performance debug.

Parameters:
- REG_AW, 5, register-file address width
- CNT_W, 32, width of each performance counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- rs1_d  input  REG_AW  source register 1 of the instruction in D
- rs2_d  input  REG_AW  source register 2 of the instruction in D
- use_rs1_d  input  1  instruction in D reads rs1
- use_rs2_d  input  1  instruction in D reads rs2
- rd_d  input  REG_AW  destination register of the instruction in D
- regwrite_d  input  1  instruction in D writes the register file
- load_d  input  1  instruction in D is a load (result comes from memory)
- pcsrc_e  input  1  branch/jump taken, resolved in E
- forward_srcA_e  output  2  00 = register file, 01 = W result, 10 = M ALU result
- forward_srcB_e  output  2  same encoding as forward_srcA_e
- stall_f  output  1  hold the PC
- stall_d  output  1  hold the F/D register
- flush_d  output  1  clear the F/D register
- flush_e  output  1  clear the D/E register (insert bubble)
- stall_cnt  output  CNT_W  number of load-use stall cycles
- flush_cnt  output  CNT_W  number of taken-branch flushes

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All shadow registers are 0.
  - stall_cnt = 0 and flush_cnt = 0.
  - forward_srcA_e = forward_srcB_e = 00; stall_f = stall_d = 0.
  - flush_d = pcsrc_e and flush_e = pcsrc_e (combinational pass-through, even during reset).
- Shadow pipeline, updated on the rising edge:
  - E stage holds {rs1_e, rs2_e, use_rs1_e, use_rs2_e, rd_e, regwrite_e, load_e}.
    - If flush_e = 1, E is loaded with all zeros (bubble).
    - Otherwise E captures the D inputs.
  - M stage holds {rd_m, regwrite_m, load_m} and always loads from E.
  - W stage holds {rd_w, regwrite_w} and always loads from M. M and W never stall.
- Forwarding (combinational from E/M/W state), shown for srcA; srcB is identical using rs2_e / use_rs2_e:
  - 10 if use_rs1_e, rs1_e != 0, regwrite_m, and rd_m == rs1_e.
  - Otherwise 01 if use_rs1_e, rs1_e != 0, regwrite_w, and rd_w == rs1_e.
  - Otherwise 00.
  - M has priority over W: the youngest producer wins.
  - x0 is never forwarded.
- Load-use stall:
  - lw_stall = load_e & (rd_e != 0) & ((use_rs1_d & rs1_d == rd_e) | (use_rs2_d & rs2_d == rd_e)).
  - This guarantees that a load never sits in M while its consumer is in E, so the 10 select never carries a load address.
- Output equations:
  - stall_f = stall_d = lw_stall & ~pcsrc_e.
  - flush_d = pcsrc_e.
  - flush_e = lw_stall | pcsrc_e.
  - Taken branch overrides stall: the D instruction is squashed anyway, so the pipeline must not freeze.
- Stall latency: a load-use stall lasts exactly 1 cycle. On the next cycle the load has moved to M, so lw_stall deasserts.
- Counters:
  - stall_cnt increments on every cycle where stall_d = 1.
  - flush_cnt increments on every cycle where pcsrc_e = 1.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset mid-operation: an asynchronous clear of all shadow state cancels any pending forward or stall immediately.

Decomposition:
- Package hazard_pkg holds:
  - typedef fwd_sel_t (2-bit) with constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - typedef reg_addr_t (REG_AW bits);
  - struct types for the E, M and W shadow stages.
- One natural sub-module, fwd_sel_gen, is instantiated twice (srcA and srcB).
  - Inputs: rs_e, use_e, rd_m, regwrite_m, rd_w, regwrite_w.
  - Output: fwd_sel_t.

Test Plan:
- add x5 (D, regwrite) followed by sub using rs1 = x5 → next cycle forward_srcA_e = 10; one cycle later with a W-only match → 01; no stall.
- Producers to x7 in both M and W, consumer in E reads rs2 = x7 → forward_srcB_e = 10 (M wins over W).
- lw x3 in E, D instruction reads rs2 = x3 → stall_f = stall_d = flush_e = 1 for exactly 1 cycle, stall_cnt 0 → 1; next cycle forward_srcB_e = 01.
- Writes to x0 (regwrite = 1, rd = 0) in M/W, consumer reads x0 → forward = 00; lw x0 followed by a consumer of x0 → no stall.
- pcsrc_e = 1 while lw_stall is true → flush_d = flush_e = 1, stall_f = stall_d = 0, flush_cnt +1, stall_cnt unchanged.
- Drop rst_n between clock edges while a forward is active → outputs go to 00/0 immediately, counters go to 0; after release, a bubble-only pipeline gives forward = 00.
